// File: rtl/div_pkg.sv
// Shared state encoding, defaults and helpers for the two-requester divider arbiter.
package div_pkg;

    localparam int DIV_DATA_W  = 16;
    localparam int DIV_TIMEOUT = 64;
    localparam int CNT_W       = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } div_state_e;

    function automatic logic [1:0] id_to_onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/div_rr_pick.sv
// Two-way round-robin picker: on contention the requester that was not served last wins.
module div_rr_pick (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/div_arbiter.sv
// Arbitrates two requesters onto one shared multi-cycle divider, with divide-by-zero
// bypass and a WAIT-state timeout that returns a flagged zero result.
module div_arbiter
    import div_pkg::*;
#(
    parameter int DATA_W  = DIV_DATA_W,
    parameter int TIMEOUT = DIV_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic [1:0]        rsp_valid,
    input  logic [1:0]        rsp_ack,
    output logic [DATA_W-1:0] rsp_q,
    output logic [DATA_W-1:0] rsp_r,
    output logic              rsp_dbz,
    output logic              rsp_tmo,
    output logic              div_start,
    output logic [DATA_W-1:0] div_a,
    output logic [DATA_W-1:0] div_b,
    input  logic              div_done,
    input  logic [DATA_W-1:0] div_q,
    input  logic [DATA_W-1:0] div_r
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    div_state_e        state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              id_q, id_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] q_q, q_d;
    logic [DATA_W-1:0] r_q, r_d;
    logic              dbz_q, dbz_d;
    logic              tmo_q, tmo_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [1:0]        grant;
    logic              win_id;
    logic [DATA_W-1:0] win_a;
    logic [DATA_W-1:0] win_b;

    div_rr_pick u_pick (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    assign win_id = grant[1];
    assign win_a  = win_id ? req1_a : req0_a;
    assign win_b  = win_id ? req1_b : req0_b;

    // Divider operands come straight from the captured job so they stay stable through WAIT.
    assign div_a   = a_q;
    assign div_b   = b_q;
    assign rsp_q   = q_q;
    assign rsp_r   = r_q;
    assign rsp_dbz = dbz_q;
    assign rsp_tmo = tmo_q;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        a_d          = a_q;
        b_d          = b_q;
        q_d          = q_q;
        r_d          = r_q;
        dbz_d        = dbz_q;
        tmo_d        = tmo_q;
        cnt_d        = cnt_q;
        req_ready    = 2'b00;
        rsp_valid    = 2'b00;
        div_start    = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = grant;
                if (grant != 2'b00) begin
                    id_d  = win_id;
                    a_d   = win_a;
                    b_d   = win_b;
                    tmo_d = 1'b0;
                    cnt_d = '0;
                    // A zero divisor never reaches the divider; the result is formed here.
                    if (win_b == '0) begin
                        q_d     = '1;
                        r_d     = win_a;
                        dbz_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        q_d     = '0;
                        r_d     = '0;
                        dbz_d   = 1'b0;
                        state_d = ISSUE;
                    end
                end
            end

            ISSUE: begin
                div_start = 1'b1;
                cnt_d     = '0;
                state_d   = WAIT;
            end

            WAIT: begin
                cnt_d = cnt_q + CNT_ONE;
                // A done in the final allowed cycle beats the timeout.
                if (div_done) begin
                    q_d     = div_q;
                    r_d     = div_r;
                    dbz_d   = 1'b0;
                    tmo_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    q_d     = '0;
                    r_d     = '0;
                    dbz_d   = 1'b0;
                    tmo_d   = 1'b1;
                    state_d = RESP;
                end
            end

            RESP: begin
                rsp_valid = id_to_onehot(id_q);
                if (rsp_ack[id_q]) begin
                    last_grant_d = id_q;
                    state_d      = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            q_q          <= '0;
            r_q          <= '0;
            dbz_q        <= 1'b0;
            tmo_q        <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            a_q          <= a_d;
            b_q          <= b_d;
            q_q          <= q_d;
            r_q          <= r_d;
            dbz_q        <= dbz_d;
            tmo_q        <= tmo_d;
            cnt_q        <= cnt_d;
        end
    end

endmodule

// File: tb/tb_div_arbiter.sv
// Directed self-checking bench for div_arbiter; the bench itself plays the shared divider.
module tb_div_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ack;
    logic [15:0] rsp_q, rsp_r;
    logic        rsp_dbz, rsp_tmo;
    logic        div_start;
    logic [15:0] div_a, div_b;
    logic        div_done;
    logic [15:0] div_q, div_r;

    int vectors    = 0;
    int miscompares = 0;
    int start_cnt  = 0;

    div_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req0_a    (req0_a),
        .req0_b    (req0_b),
        .req1_a    (req1_a),
        .req1_b    (req1_b),
        .rsp_valid (rsp_valid),
        .rsp_ack   (rsp_ack),
        .rsp_q     (rsp_q),
        .rsp_r     (rsp_r),
        .rsp_dbz   (rsp_dbz),
        .rsp_tmo   (rsp_tmo),
        .div_start (div_start),
        .div_a     (div_a),
        .div_b     (div_b),
        .div_done  (div_done),
        .div_q     (div_q),
        .div_r     (div_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && div_start) start_cnt++;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) cyc();
        vectors++;
        if ({req_ready, rsp_valid, rsp_dbz, rsp_tmo, div_start} !== 7'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_ctrl: got %b expected %b",
                     {req_ready, rsp_valid, rsp_dbz, rsp_tmo, div_start}, 7'b0);
        end
        vectors++;
        if ({rsp_q, rsp_r, div_a, div_b} !== 64'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_data: got %h expected %h", {rsp_q, rsp_r, div_a, div_b}, 64'h0);
        end
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_basic();
        int s0;
        s0 = start_cnt;
        req_valid = 2'b01; req0_a = 16'd100; req0_b = 16'd7;
        #1;
        vectors++;
        if (req_ready !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL basic_ready: got %b expected %b", req_ready, 2'b01);
        end
        cyc();
        req_valid = 2'b00;
        #1;
        vectors++;
        if ({div_start, div_a, div_b} !== {1'b1, 16'd100, 16'd7}) begin
            miscompares++;
            $display("[TB] FAIL basic_issue: got %h expected %h", {div_start, div_a, div_b}, {1'b1, 16'd100, 16'd7});
        end
        repeat (16) cyc();
        vectors++;
        if (rsp_valid !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL basic_early: got %b expected %b", rsp_valid, 2'b00);
        end
        cyc();
        div_done = 1'b1; div_q = 16'd14; div_r = 16'd2;
        cyc();
        div_done = 1'b0; div_q = '0; div_r = '0;
        #1;
        vectors++;
        if ({rsp_valid, rsp_q, rsp_r, rsp_dbz, rsp_tmo} !== {2'b01, 16'd14, 16'd2, 1'b0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL basic_rsp: got %h expected %h",
                     {rsp_valid, rsp_q, rsp_r, rsp_dbz, rsp_tmo}, {2'b01, 16'd14, 16'd2, 1'b0, 1'b0});
        end
        vectors++;
        if (start_cnt - s0 !== 1) begin
            miscompares++;
            $display("[TB] FAIL basic_starts: got %0d expected %0d", start_cnt - s0, 1);
        end
        rsp_ack = 2'b01;
        cyc();
        rsp_ack = 2'b00;
        #1;
        vectors++;
        if (rsp_valid !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL basic_ack: got %b expected %b", rsp_valid, 2'b00);
        end
    endtask

    task automatic test_dbz();
        int s0;
        s0 = start_cnt;
        req_valid = 2'b10; req1_a = 16'h1234; req1_b = 16'h0000;
        #1;
        vectors++;
        if (req_ready !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL dbz_ready: got %b expected %b", req_ready, 2'b10);
        end
        cyc();
        req_valid = 2'b00;
        #1;
        vectors++;
        if ({rsp_valid, rsp_q, rsp_r, rsp_dbz, rsp_tmo, div_start} !==
            {2'b10, 16'hFFFF, 16'h1234, 1'b1, 1'b0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL dbz_rsp: got %h expected %h",
                     {rsp_valid, rsp_q, rsp_r, rsp_dbz, rsp_tmo, div_start},
                     {2'b10, 16'hFFFF, 16'h1234, 1'b1, 1'b0, 1'b0});
        end
        rsp_ack = 2'b10;
        cyc();
        rsp_ack = 2'b00;
        #1;
        vectors++;
        if ({start_cnt - s0, rsp_valid} !== {32'd0, 2'b00}) begin
            miscompares++;
            $display("[TB] FAIL dbz_nostart: got starts=%0d valid=%b expected starts=0 valid=00",
                     start_cnt - s0, rsp_valid);
        end
    endtask

    task automatic test_round_robin();
        req0_a = 16'd50; req0_b = 16'd7; req1_a = 16'd60; req1_b = 16'd9;
        req_valid = 2'b11;
        for (int k = 0; k < 6; k++) begin
            logic [1:0]  exp_g;
            logic [15:0] exp_a, exp_b, exp_q, exp_r;
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_a = (k % 2 == 0) ? 16'd50 : 16'd60;
            exp_b = (k % 2 == 0) ? 16'd7 : 16'd9;
            exp_q = (k % 2 == 0) ? 16'd7 : 16'd6;
            exp_r = (k % 2 == 0) ? 16'd1 : 16'd6;
            #1;
            vectors++;
            if (req_ready !== exp_g) begin
                miscompares++;
                $display("[TB] FAIL rr_grant%0d: got %b expected %b", k, req_ready, exp_g);
            end
            cyc();
            #1;
            vectors++;
            if ({req_ready, div_start, div_a, div_b} !== {2'b00, 1'b1, exp_a, exp_b}) begin
                miscompares++;
                $display("[TB] FAIL rr_issue%0d: got %h expected %h", k,
                         {req_ready, div_start, div_a, div_b}, {2'b00, 1'b1, exp_a, exp_b});
            end
            cyc();
            div_done = 1'b1; div_q = exp_q; div_r = exp_r;
            cyc();
            div_done = 1'b0;
            #1;
            vectors++;
            if ({rsp_valid, rsp_q, rsp_r} !== {exp_g, exp_q, exp_r}) begin
                miscompares++;
                $display("[TB] FAIL rr_rsp%0d: got %h expected %h", k,
                         {rsp_valid, rsp_q, rsp_r}, {exp_g, exp_q, exp_r});
            end
            rsp_ack = exp_g;
            cyc();
            rsp_ack = 2'b00;
        end
        req_valid = 2'b00;
    endtask

    task automatic test_timeout();
        req_valid = 2'b01; req0_a = 16'd200; req0_b = 16'd3;
        cyc();
        req_valid = 2'b00;
        cyc();
        repeat (63) cyc();
        #1;
        vectors++;
        if (rsp_valid !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL tmo_early: got %b expected %b", rsp_valid, 2'b00);
        end
        cyc();
        #1;
        vectors++;
        if ({rsp_valid, rsp_q, rsp_r, rsp_dbz, rsp_tmo} !== {2'b01, 16'h0, 16'h0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL tmo_rsp: got %h expected %h",
                     {rsp_valid, rsp_q, rsp_r, rsp_dbz, rsp_tmo}, {2'b01, 16'h0, 16'h0, 1'b0, 1'b1});
        end
        div_done = 1'b1; div_q = 16'hAAAA; div_r = 16'h5555;
        cyc();
        div_done = 1'b0;
        #1;
        vectors++;
        if ({rsp_valid, rsp_q, rsp_r, rsp_dbz, rsp_tmo} !== {2'b01, 16'h0, 16'h0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL tmo_late_done: got %h expected %h",
                     {rsp_valid, rsp_q, rsp_r, rsp_dbz, rsp_tmo}, {2'b01, 16'h0, 16'h0, 1'b0, 1'b1});
        end
        rsp_ack = 2'b01;
        cyc();
        rsp_ack = 2'b00;
        div_done = 1'b1;
        cyc();
        div_done = 1'b0;
        #1;
        vectors++;
        if ({rsp_valid, div_start} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL tmo_idle_done: got %b expected %b", {rsp_valid, div_start}, 3'b000);
        end
        req_valid = 2'b01; req0_a = 16'd200; req0_b = 16'd3;
        cyc();
        req_valid = 2'b00;
        cyc();
        div_done = 1'b1; div_q = 16'd66; div_r = 16'd2;
        cyc();
        div_done = 1'b0;
        #1;
        vectors++;
        if ({rsp_valid, rsp_q, rsp_r, rsp_dbz, rsp_tmo} !== {2'b01, 16'd66, 16'd2, 1'b0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL tmo_next_job: got %h expected %h",
                     {rsp_valid, rsp_q, rsp_r, rsp_dbz, rsp_tmo}, {2'b01, 16'd66, 16'd2, 1'b0, 1'b0});
        end
        rsp_ack = 2'b01;
        cyc();
        rsp_ack = 2'b00;
    endtask

    task automatic test_done_at_expiry();
        req_valid = 2'b01; req0_a = 16'h0085; req0_b = 16'd2;
        cyc();
        req_valid = 2'b00;
        cyc();
        repeat (63) cyc();
        div_done = 1'b1; div_q = 16'h0042; div_r = 16'h0001;
        cyc();
        div_done = 1'b0;
        #1;
        vectors++;
        if ({rsp_valid, rsp_q, rsp_r, rsp_dbz, rsp_tmo} !== {2'b01, 16'h0042, 16'h0001, 1'b0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL expiry_done_wins: got %h expected %h",
                     {rsp_valid, rsp_q, rsp_r, rsp_dbz, rsp_tmo}, {2'b01, 16'h0042, 16'h0001, 1'b0, 1'b0});
        end
        rsp_ack = 2'b01;
        cyc();
        rsp_ack = 2'b00;
    endtask

    task automatic test_reset_mid();
        req_valid = 2'b10; req1_a = 16'd9; req1_b = 16'd2;
        cyc();
        req_valid = 2'b00;
        repeat (3) cyc();
        rst = 1'b1;
        #1;
        vectors++;
        if ({req_ready, rsp_valid, rsp_q, rsp_r, rsp_dbz, rsp_tmo, div_start, div_a, div_b} !== 71'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_async: got %h expected %h",
                     {req_ready, rsp_valid, rsp_q, rsp_r, rsp_dbz, rsp_tmo, div_start, div_a, div_b}, 71'h0);
        end
        cyc();
        rst = 1'b0;
        div_done = 1'b1; div_q = 16'd4; div_r = 16'd1;
        cyc();
        div_done = 1'b0; div_q = '0; div_r = '0;
        repeat (2) cyc();
        #1;
        vectors++;
        if ({req_ready, rsp_valid, rsp_q, rsp_r, rsp_dbz, rsp_tmo, div_start, div_a, div_b} !== 71'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_quiet: got %h expected %h",
                     {req_ready, rsp_valid, rsp_q, rsp_r, rsp_dbz, rsp_tmo, div_start, div_a, div_b}, 71'h0);
        end
        req_valid = 2'b11;
        #1;
        vectors++;
        if (req_ready !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_first: got %b expected %b", req_ready, 2'b01);
        end
        req_valid = 2'b00;
        #1;
    endtask

    task automatic test_ack_filter();
        req_valid = 2'b01; req0_a = 16'd81; req0_b = 16'd9;
        cyc();
        req_valid = 2'b00;
        cyc();
        rsp_ack = 2'b11;
        cyc();
        rsp_ack = 2'b00;
        div_done = 1'b1; div_q = 16'd9; div_r = 16'd0;
        cyc();
        div_done = 1'b0;
        #1;
        vectors++;
        if ({rsp_valid, rsp_q, rsp_r} !== {2'b01, 16'd9, 16'd0}) begin
            miscompares++;
            $display("[TB] FAIL ack_early_ignored: got %h expected %h",
                     {rsp_valid, rsp_q, rsp_r}, {2'b01, 16'd9, 16'd0});
        end
        rsp_ack = 2'b10;
        repeat (2) cyc();
        #1;
        vectors++;
        if ({rsp_valid, rsp_q, rsp_r} !== {2'b01, 16'd9, 16'd0}) begin
            miscompares++;
            $display("[TB] FAIL ack_wrong_held: got %h expected %h",
                     {rsp_valid, rsp_q, rsp_r}, {2'b01, 16'd9, 16'd0});
        end
        rsp_ack = 2'b01;
        req_valid = 2'b01; req0_a = 16'h0014; req0_b = 16'h0000;
        #1;
        vectors++;
        if (req_ready !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL ready_in_resp: got %b expected %b", req_ready, 2'b00);
        end
        cyc();
        rsp_ack = 2'b00;
        #1;
        vectors++;
        if ({rsp_valid, req_ready} !== {2'b00, 2'b01}) begin
            miscompares++;
            $display("[TB] FAIL b2b_ready: got %b expected %b", {rsp_valid, req_ready}, {2'b00, 2'b01});
        end
        cyc();
        req_valid = 2'b00;
        #1;
        vectors++;
        if ({rsp_valid, rsp_q, rsp_r, rsp_dbz, rsp_tmo} !== {2'b01, 16'hFFFF, 16'h0014, 1'b1, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL b2b_dbz: got %h expected %h",
                     {rsp_valid, rsp_q, rsp_r, rsp_dbz, rsp_tmo}, {2'b01, 16'hFFFF, 16'h0014, 1'b1, 1'b0});
        end
        rsp_ack = 2'b01;
        cyc();
        rsp_ack = 2'b00;
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 2'b00;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        rsp_ack = 2'b00;
        div_done = 1'b0; div_q = '0; div_r = '0;

        test_reset();
        test_basic();
        test_dbz();
        test_round_robin();
        test_timeout();
        test_done_at_expiry();
        test_reset_mid();
        test_ack_filter();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
